ahb_bus_arbiter: RTL
====================

// Module: ahb_bus_arbiter
// PURPOSE
//  Central AHB-2 bus arbiter that shares one address/data bus between NUM_MASTERS masters.
//  - Samples hbusreq/hlock from each master and drives a one-hot hgrant.
//  - Drives hmaster/hmastlock to the address/data mux and to the slaves.
//  - Round-robin fairness; fixed-length bursts and locked sequences are never broken.
//  - Idle bus is parked on DEFAULT_MASTER.
// PARAMETERS
//  NUM_MASTERS     4   number of requesting masters, 2..16 (hmaster is 4 bits)
//  DEFAULT_MASTER  0   parking master: granted at reset and when no hbusreq is active
// PORTS
//  hclk       in   1            bus clock; all state on rising edge
//  hreset     in   1            asynchronous reset, active-high
//  hbusreq    in   NUM_MASTERS  bus request, bit i = master i
//  hlock      in   NUM_MASTERS  locked-access request, bit i = master i
//  htrans     in   2            transfer type of current address phase (IDLE=0,BUSY=1,NONSEQ=2,SEQ=3)
//  hburst     in   3            burst type of current address phase (SINGLE,INCR,WRAP4,INCR4,WRAP8,INCR8,WRAP16,INCR16)
//  hready     in   1            transfer done / bus advance from slave mux
//  hresp      in   2            slave response (OKAY=0,ERROR=1,RETRY=2,SPLIT=3)
//  hgrant     out  NUM_MASTERS  one-hot grant, registered
//  hmaster    out  4            index of master owning the current address phase, registered
//  hmastlock  out  1            current address phase is part of a locked sequence, registered
// BEHAVIOUR
//  Reset (hreset=1, async): hgrant=1<<DEFAULT_MASTER, hmaster=DEFAULT_MASTER, hmastlock=0,
//   beat_cnt=0, rr_last=DEFAULT_MASTER, state=FREE.
//  All state updates occur only on edges with hready=1. With hready=0 every register holds.
//  Beat counter (beat_cnt, 4 bits), updated on hready=1 edges:
//   - NONSEQ with fixed burst (WRAP4/INCR4/WRAP8/INCR8/WRAP16/INCR16): beat_cnt_next = len-1 (3, 7 or 15).
//   - SEQ with beat_cnt>0: beat_cnt_next = beat_cnt-1.
//   - IDLE, or hresp=ERROR/RETRY/SPLIT: beat_cnt_next = 0 (early burst termination).
//   - NONSEQ SINGLE/INCR: beat_cnt_next = 0.
//   - BUSY, or SEQ with beat_cnt=0: beat_cnt_next = beat_cnt.
//  FSM (state encodes the hold reason, evaluated on hready=1 edges in this priority):
//   - LOCK:  hlock[granted]=1. Grant held. Exit when hlock[granted]=0 at a hready=1 edge.
//   - BURST: beat_cnt_next>1. Grant held. Exit when beat_cnt_next<=1.
//   - FREE:  otherwise; re-arbitrate on this edge.
//   - beat_cnt_next<=1 releases during the penultimate beat, so the new master's NONSEQ directly follows the last beat.
//  Arbitration in FREE:
//   - Winner = first requester scanning from rr_last+1 upward, modulo NUM_MASTERS.
//   - The current holder still requesting is granted again only if no other master requests.
//   - No requests: winner = DEFAULT_MASTER.
//   - hgrant <= onehot(winner); rr_last <= winner, but only if the winner was requesting.
//  Ownership handover:
//   - On every hready=1 edge: hmaster <= index(hgrant) and hmastlock <= hlock[index(hgrant)],
//     using pre-edge values of hgrant/hlock.
//   - hmaster therefore lags hgrant by exactly one hready=1 edge (address-phase ownership).
//  Boundaries:
//   - hbusreq changes while held: ignored until the next FREE edge.
//   - A holder dropping hbusreq mid-burst keeps the grant until release.
//   - Simultaneous hlock and fixed burst: LOCK dominates; after unlock, BURST still applies if beat_cnt_next>1.
//   - BUSY beats never count.
//   - Wait states (hready=0) stretch every phase without changing grant.
//   - hreset mid-burst or mid-lock returns immediately to reset values.
//  Invariant: hgrant is always exactly one-hot.
// TESTING
//  1. Reset, no requests -> hgrant=0001, hmaster=0, hmastlock=0; parks on master 0.
//  2. hbusreq=0110, hready=1, single transfers -> grants alternate m1,m2,m1,m2; hmaster follows one edge later.
//  3. m1 granted starts INCR4 (NONSEQ+3 SEQ), m3 requests on beat 1
//     -> hgrant stays 0010 until edge accepting 3rd beat, then 1000; m3 NONSEQ follows 4th beat.
//  4. INCR8 with 2 BUSY cycles and hready=0 for 3 cycles mid-burst, m2 requesting
//     -> grant held through all 8 SEQ/NONSEQ beats; handover on 7th accepted beat.
//  5. m2 hlock=1 for 5 transfers while m0,m1 request -> hgrant=0100 and hmastlock=1 throughout;
//     release one hready edge after hlock drops, then round-robin resumes at m3/m0.
//  6. hreset asserted mid-WRAP16 (beat_cnt=9) -> all outputs to reset values asynchronously;
//     after release, arbitration starts FREE.

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter: round-robin AHB-2 arbiter with burst/lock holding and default-master parking
module ahb_bus_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                   hclk,
   input  logic                   hreset,
   input  logic [NUM_MASTERS-1:0] hbusreq,
   input  logic [NUM_MASTERS-1:0] hlock,
   input  logic [1:0]             htrans,
   input  logic [2:0]             hburst,
   input  logic                   hready,
   input  logic [1:0]             hresp,
   output logic [NUM_MASTERS-1:0] hgrant,
   output logic [3:0]             hmaster,
   output logic                   hmastlock
);
   typedef enum logic [1:0] {FREE, BURST, LOCK} state_t;
   state_t                 w_state;
   logic [NUM_MASTERS-1:0] r_grant, w_win_oh, w_others;
   logic [3:0]             r_master, r_beat_cnt, r_rr_last, w_gidx, w_beat_next, w_win, w_len;
   logic                   r_mastlock, w_glock, w_greq, w_found, w_win_req;
   assign hgrant    = r_grant;
   assign hmaster   = r_master;
   assign hmastlock = r_mastlock;
   always_comb begin
      w_gidx  = '0;
      w_glock = 1'b0;
      w_greq  = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (r_grant[i]) begin
            w_gidx  = 4'(i);
            w_glock = hlock[i];
            w_greq  = hbusreq[i];
         end
   end
   // Errors/retries/splits and IDLE terminate a burst early; BUSY never counts
   always_comb begin
      w_len       = hburst >= 3'd6 ? 4'd15 : hburst >= 3'd4 ? 4'd7 : hburst >= 3'd2 ? 4'd3 : 4'd0;
      w_beat_next = (hresp != 2'd0 || htrans == 2'd0) ? 4'd0
                  : htrans == 2'd2 ? w_len
                  : (htrans == 2'd3 && r_beat_cnt != 4'd0) ? r_beat_cnt - 4'd1
                  : r_beat_cnt;
      w_state     = w_glock ? LOCK : w_beat_next > 4'd1 ? BURST : FREE;
   end
   // Other requesters are scanned from rr_last+1 first; the holder only wins when alone
   always_comb begin
      w_others = hbusreq & ~r_grant;
      w_found  = 1'b0;
      w_win    = 4'(DEFAULT_MASTER);
      w_win_oh = NUM_MASTERS'(1) << DEFAULT_MASTER;
      for (int i = 0; i < NUM_MASTERS; i++)
         if (!w_found && w_others[i] && 4'(i) > r_rr_last) begin
            w_found     = 1'b1;
            w_win       = 4'(i);
            w_win_oh    = '0;
            w_win_oh[i] = 1'b1;
         end
      for (int i = 0; i < NUM_MASTERS; i++)
         if (!w_found && w_others[i] && 4'(i) <= r_rr_last) begin
            w_found     = 1'b1;
            w_win       = 4'(i);
            w_win_oh    = '0;
            w_win_oh[i] = 1'b1;
         end
      if (!w_found && w_greq) begin
         w_win    = w_gidx;
         w_win_oh = r_grant;
      end
      w_win_req = w_found | w_greq;
   end
   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         r_grant    <= NUM_MASTERS'(1) << DEFAULT_MASTER;
         r_master   <= 4'(DEFAULT_MASTER);
         r_mastlock <= 1'b0;
         r_beat_cnt <= '0;
         r_rr_last  <= 4'(DEFAULT_MASTER);
      end else if (hready) begin
         r_beat_cnt <= w_beat_next;
         r_master   <= w_gidx;
         r_mastlock <= w_glock;
         if (w_state == FREE) begin
            r_grant <= w_win_oh;
            if (w_win_req) r_rr_last <= w_win;
         end
      end
   end
endmodule
